// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums N_PROD multiplier products per block; optional macro SATURATE_EN clamps instead of wrapping
module product_accumulator #(
    parameter int N_PROD = 4,
    parameter int ACC_W  = 10,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PROD - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ACC_W:0]   sum_raw;
    logic             carry;
    logic [ACC_W-1:0] sum_next;
    logic             accept;

    // Adder: one extra bit catches the carry out of the accumulator MSB
    always_comb begin
        sum_raw = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_data};
        carry   = sum_raw[ACC_W];
`ifdef SATURATE_EN
        sum_next = carry ? ACC_MAX : sum_raw[ACC_W-1:0];
`else
        sum_next = sum_raw[ACC_W-1:0];
`endif
    end

    // Next-state logic: collect products in ACC, present the block sum in HOLD
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        count_d     = count_q;
        accept      = in_valid && in_ready_q;

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    ovf_d = ovf_q | carry;
                    if (count_q == LAST_IDX) begin
                        out_data_d  = sum_next;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = ST_HOLD;
                        acc_d       = '0;
                        count_d     = '0;
                    end else begin
                        acc_d   = sum_next;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Input is closed this cycle; reopening happens on the next edge
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State register: rst and clr share the same effect, both override the handshake
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator (default and 8-bit/2-product instances)
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_clr = 1'b0;
    logic [7:0] a_in_data = '0;
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [9:0] a_out_data;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic       a_ovf;
    logic [2:0] a_count;

    logic       b_clr = 1'b0;
    logic [7:0] b_in_data = '0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic       b_ovf;
    logic [1:0] b_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N_PROD(4), .ACC_W(10), .CNT_W(3)) u_dut_a (
        .clk(clk), .rst(rst), .clr(a_clr),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ovf(a_ovf), .count(a_count)
    );

    product_accumulator #(.N_PROD(2), .ACC_W(8), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .clr(b_clr),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ovf(b_ovf), .count(b_count)
    );

    typedef struct {
        int p[4];
        int sum;
        int ovf;
    } vec_t;

    typedef struct {
        bit hold;
        int sum;
        int n;
        int exp_data;
        bit exp_ovf;
    } model_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected block result straight from the arithmetic rules
    function automatic int block_data(input int total, input int w);
        int maxv;
        maxv = (1 << w) - 1;
`ifdef SATURATE_EN
        return (total > maxv) ? maxv : total;
`else
        return total % (1 << w);
`endif
    endfunction

    // One cycle of the behavioural model: running block total, hold flag
    function automatic model_t step(input model_t m, input bit c, input bit v, input int d,
                                    input bit ordy, input int np, input int w);
        model_t r;
        r = m;
        if (c) begin
            r.hold = 0; r.sum = 0; r.n = 0;
        end else if (!m.hold && v) begin
            r.sum = m.sum + d;
            r.n   = m.n + 1;
            if (r.n == np) begin
                r.exp_data = block_data(r.sum, w);
                r.exp_ovf  = (r.sum > (1 << w) - 1);
                r.hold = 1; r.sum = 0; r.n = 0;
            end
        end else if (m.hold && ordy) begin
            r.hold = 0;
        end
        return r;
    endfunction

    task automatic a_send(input int d);
        a_in_valid = 1'b1;
        a_in_data  = 8'(d);
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input int d);
        b_in_valid = 1'b1;
        b_in_data  = 8'(d);
        tick();
        b_in_valid = 1'b0;
    endtask

    task automatic a_handshake();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("a_hs_out_valid", a_out_valid, 0);
        chk("a_hs_in_ready", a_in_ready, 1);
    endtask

    task automatic b_handshake();
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("b_hs_out_valid", b_out_valid, 0);
    endtask

    vec_t   vecs[4];
    model_t ma, mb;
    int     exp_b;

    initial begin
        vecs[0].p = '{110, 36, 225, 0};   vecs[0].sum = 371;  vecs[0].ovf = 0;
        vecs[1].p = '{255, 255, 255, 255}; vecs[1].sum = 1020; vecs[1].ovf = 0;
        vecs[2].p = '{0, 0, 0, 0};         vecs[2].sum = 0;    vecs[2].ovf = 0;
        vecs[3].p = '{200, 200, 200, 200}; vecs[3].sum = 800;  vecs[3].ovf = 0;

        // Reset held two cycles with in_valid high
        rst = 1'b1; a_in_valid = 1'b1; a_in_data = 8'd5;
        tick(); tick();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_count", a_count, 0);
        chk("rst_ovf", a_ovf, 0);
        rst = 1'b0; a_in_valid = 1'b0;
        tick();
        chk("rst_no_accept", a_count, 0);

        // Table-driven full blocks with one-cycle latency check
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) a_send(vecs[i].p[k]);
            chk("vec_early_valid", a_out_valid, 0);
            chk("vec_count3", a_count, 3);
            a_send(vecs[i].p[3]);
            chk("vec_out_valid", a_out_valid, 1);
            chk("vec_out_data", a_out_data, vecs[i].sum);
            chk("vec_ovf", a_ovf, vecs[i].ovf);
            chk("vec_in_ready_hold", a_in_ready, 0);
            a_handshake();
        end

        // Bubbles between products, then backpressure with ignored inputs
        for (int k = 1; k <= 4; k++) begin
            a_send(k);
            if (k < 4) begin
                chk("bub_count", a_count, k);
                tick();
                chk("bub_count_idle", a_count, k);
            end
        end
        for (int i = 0; i < 5; i++) begin
            a_in_valid = (i % 2 == 0);
            a_in_data  = 8'd99;
            tick();
            chk("bp_out_valid", a_out_valid, 1);
            chk("bp_out_data", a_out_data, 10);
            chk("bp_in_ready", a_in_ready, 0);
            chk("bp_count", a_count, 0);
        end
        a_in_valid = 1'b0;
        a_handshake();
        for (int k = 0; k < 4; k++) a_send(5);
        chk("bp_next_block", a_out_data, 20);
        chk("bp_next_valid", a_out_valid, 1);
        a_handshake();

        // Overflow on the 8-bit, 2-product instance
`ifdef SATURATE_EN
        exp_b = 255;
`else
        exp_b = 44;
`endif
        b_send(200); b_send(100);
        chk("ovf_out_valid", b_out_valid, 1);
        chk("ovf_out_data", b_out_data, exp_b);
        chk("ovf_flag", b_ovf, 1);
        b_handshake();
        chk("ovf_cleared", b_ovf, 0);
        b_send(5); b_send(6);
        chk("ovf_next_data", b_out_data, 11);
        chk("ovf_next_flag", b_ovf, 0);
        b_handshake();

        // clr discards a partial block
        a_send(50); a_send(60);
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        chk("clr_count", a_count, 0);
        for (int k = 1; k <= 4; k++) a_send(k);
        chk("clr_block_data", a_out_data, 10);
        chk("clr_block_valid", a_out_valid, 1);
        // clr in HOLD drops the result without a handshake
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        chk("clr_hold_valid", a_out_valid, 0);
        chk("clr_hold_in_ready", a_in_ready, 1);

        // rst coinciding with the final accept
        a_send(1); a_send(2); a_send(3);
        rst = 1'b1; a_in_valid = 1'b1; a_in_data = 8'd4;
        tick();
        rst = 1'b0; a_in_valid = 1'b0;
        chk("rstmid_valid", a_out_valid, 0);
        chk("rstmid_count", a_count, 0);
        tick();
        chk("rstmid_valid2", a_out_valid, 0);
        a_send(7); a_send(8); a_send(9); a_send(10);
        chk("rstmid_next_data", a_out_data, 34);
        chk("rstmid_next_valid", a_out_valid, 1);
        a_handshake();

        // Randomised traffic against the behavioural model
        rst = 1'b1; tick(); rst = 1'b0;
        ma = '{hold: 0, sum: 0, n: 0, exp_data: 0, exp_ovf: 0};
        mb = ma;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_in_valid  = ($urandom_range(0, 2) != 0);
            a_in_data   = 8'($urandom_range(0, 255));
            a_out_ready = ($urandom_range(0, 3) == 0);
            a_clr       = ($urandom_range(0, 79) == 0);
            b_in_valid  = ($urandom_range(0, 2) != 0);
            b_in_data   = 8'($urandom_range(0, 255));
            b_out_ready = ($urandom_range(0, 2) == 0);
            b_clr       = ($urandom_range(0, 79) == 0);
            ma = step(ma, a_clr, a_in_valid, int'(a_in_data), a_out_ready, 4, 10);
            mb = step(mb, b_clr, b_in_valid, int'(b_in_data), b_out_ready, 2, 8);
            tick();
            chk("rnd_a_in_ready", a_in_ready, !ma.hold);
            chk("rnd_a_out_valid", a_out_valid, ma.hold);
            chk("rnd_a_count", a_count, ma.n);
            chk("rnd_a_ovf", a_ovf, ma.hold ? ma.exp_ovf : (ma.sum > 1023));
            if (ma.hold) chk("rnd_a_out_data", a_out_data, ma.exp_data);
            chk("rnd_b_in_ready", b_in_ready, !mb.hold);
            chk("rnd_b_out_valid", b_out_valid, mb.hold);
            chk("rnd_b_count", b_count, mb.n);
            chk("rnd_b_ovf", b_ovf, mb.hold ? mb.exp_ovf : (mb.sum > 255));
            if (mb.hold) chk("rnd_b_out_data", b_out_data, mb.exp_data);
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0; a_clr = 1'b0; b_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 array multiplier.
- Consumes the 8-bit product stream over a valid/ready handshake and sums N_PROD consecutive products into one block sum.
- Presents each block sum on a held valid/ready output port to the next stage, e.g. a display or register file.
- Turns the combinational multiplier into the front half of a multiply-accumulate path.

Parameters:
N_PROD, 4, number of products summed per block (>=1)
ACC_W, 10, accumulator/output width in bits (>=8); default covers 4*225=900 without overflow
CNT_W, 3, width of sample counter; must hold N_PROD

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
clr  in  1  synchronous abort: discards partial block, same effect as rst on state/acc, lower priority than rst
in_data  in  8  product from multiplier (C output)
in_valid  in  1  in_data valid this cycle
in_ready  out  1  stage can accept in_data this cycle
out_data  out  ACC_W  completed block sum
out_valid  out  1  out_data valid, held until accepted
out_ready  in  1  downstream accepts out_data
ovf  out  1  overflow occurred in the current/presented block
count  out  CNT_W  products accepted in current block

Behaviour:
- Reset is synchronous, active-high, sampled on the rising edge of clk. Single clock domain.
- Reset/clr values: state=ACC, acc=0, count=0, out_data=0, out_valid=0, ovf=0, in_ready=1.
- States: ACC (collecting) and HOLD (result presented).
- Accept event: in_valid && in_ready at a rising edge. Cycles without this event are bubbles and change nothing.
- In ACC:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc + zero-extended in_data; count <= count+1.
  - On accept with count==N_PROD-1, the final sum goes to out_data, out_valid <= 1, state <= HOLD, acc <= 0, count <= 0.
  - Latency: out_valid rises the cycle after the last product is accepted.
- In HOLD:
  - in_ready=0; in_valid is ignored.
  - out_data, out_valid and ovf are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid <= 0, ovf <= 0, state <= ACC. in_ready is 1 the following cycle; there is no same-cycle accept.
- Arithmetic:
  - Sum is unsigned.
  - ovf is set sticky within the block when the carry out of bit ACC_W-1 occurs.
  - Overflow handling depends on SATURATE_EN (see Optional Feature).
- Priority: rst > clr > handshake.
- clr in HOLD discards the presented result (out_valid <= 0).
- rst or clr in the same cycle as the final accept: reset wins, and no result is produced.
- N_PROD=1: every accepted product goes straight to HOLD.
- out_data retains the last result after acceptance. It is only meaningful while out_valid=1.

Optional Feature:
- Macro: SATURATE_EN.
- Defined: any addition that would exceed 2^ACC_W-1 clamps acc to 2^ACC_W-1. Later adds in the block stay clamped. ovf=1.
- Undefined: the sum wraps modulo 2^ACC_W. ovf=1 on any wrap.
- Port list is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0, count=0, ovf=0. No accept counted.
- Basic block (defaults): accept 110 (10*11), 36 (12*3), 225, 0 on consecutive cycles -> out_valid=1 exactly one cycle after 4th accept, out_data=371, ovf=0.
- Bubbles and backpressure:
  - Stimulus: products 1,2,3,4 with idle cycles between them, and out_ready=0 for 5 cycles after the block completes.
  - Required: out_data=10 held stable; in_ready=0 throughout HOLD; extra in_valid pulses ignored.
  - Then out_ready=1 -> out_valid falls next edge, in_ready=1 the cycle after, and the next block starts from 0.
- Overflow (ACC_W=8, N_PROD=2):
  - Stimulus: products 200 then 100.
  - Without SATURATE_EN -> out_data=44, ovf=1.
  - With SATURATE_EN -> out_data=255, ovf=1.
  - In both builds, the next block 5+6 -> 11 with ovf=0.
- Abort:
  - clr after accepting 50,60, then products 1,2,3,4 -> out_data=10.
  - clr asserted in HOLD -> out_valid drops next edge with no handshake.
- Reset mid-operation: rst asserted in the same cycle as the 4th accept -> out_valid stays 0, count=0, and the next full block sums correctly.
